// File: rtl/noc_router_xy.sv
// Five-port XY-routed mesh router with single-flit packets, per-input FIFOs,
// one-flit output registers and a round-robin arbiter per output.
module noc_router_xy #(
  parameter int FLIT_WIDTH = 64,
  parameter int COORD_W    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0][FLIT_WIDTH-1:0] flit_in,
  input  logic [4:0]                 valid_in,
  output logic [4:0]                 ready_out,
  output logic [4:0][FLIT_WIDTH-1:0] flit_out,
  output logic [4:0]                 valid_out,
  input  logic [4:0]                 ready_in
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);
  localparam logic [CNT_W-1:0]   FULL_C = CNT_W'(FIFO_DEPTH);

  // One-hot output direction: bit 0 local, 1 north, 2 east, 3 south, 4 west.
  function automatic logic [4:0] route(input logic [FLIT_WIDTH-1:0] f);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = f[2*COORD_W-1:COORD_W];
    dy = f[COORD_W-1:0];
    if (dx > MY_X_C)      return 5'b00100;
    else if (dx < MY_X_C) return 5'b10000;
    else if (dy > MY_Y_C) return 5'b00010;
    else if (dy < MY_Y_C) return 5'b01000;
    else                  return 5'b00001;
  endfunction

  // Returns {found, index} of the first request at or after ptr, wrapping mod 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] req_v, input logic [2:0] ptr);
    logic [3:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      idx = int'(ptr) + k;
      if (idx >= 5) idx = idx - 5;
      if (!r[3] && req_v[idx]) r = {1'b1, 3'(idx)};
    end
    return r;
  endfunction

  logic [FLIT_WIDTH-1:0] mem_q [5][FIFO_DEPTH];
  logic [FLIT_WIDTH-1:0] mem_d [5][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [5];
  logic [PTR_W-1:0]      wr_ptr_d [5];
  logic [PTR_W-1:0]      rd_ptr_q [5];
  logic [PTR_W-1:0]      rd_ptr_d [5];
  logic [CNT_W-1:0]      cnt_q [5];
  logic [CNT_W-1:0]      cnt_d [5];
  logic [4:0]            valid_q;
  logic [4:0]            valid_d;
  logic [FLIT_WIDTH-1:0] flit_q [5];
  logic [FLIT_WIDTH-1:0] flit_d [5];
  logic [2:0]            rr_ptr_q [5];
  logic [2:0]            rr_ptr_d [5];

  logic [FLIT_WIDTH-1:0] head [5];
  logic [4:0]            head_dir [5];
  logic [4:0]            req [5];
  logic [3:0]            pick [5];
  logic [2:0]            gnt_idx [5];
  logic [4:0]            gnt_any;
  logic [4:0]            push;
  logic [4:0]            pop;

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      ready_out[p] = !rst && (cnt_q[p] != FULL_C);
      head[p]      = mem_q[p][rd_ptr_q[p]];
      head_dir[p]  = (cnt_q[p] != '0) ? route(head[p]) : 5'b00000;
    end
  end

  // Each head requests exactly one output, so no input can win twice in a cycle.
  always_comb begin
    gnt_any = '0;
    pop     = '0;
    for (int o = 0; o < 5; o++) begin
      req[o] = '0;
      for (int p = 0; p < 5; p++) req[o][p] = head_dir[p][o];
      pick[o]    = rr_pick(req[o], rr_ptr_q[o]);
      gnt_idx[o] = pick[o][2:0];
      gnt_any[o] = pick[o][3] && (!valid_q[o] || ready_in[o]);
    end
    for (int o = 0; o < 5; o++) begin
      if (gnt_any[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int p = 0; p < 5; p++) begin
      push[p]     = valid_in[p] && ready_out[p];
      wr_ptr_d[p] = push[p] ? wr_ptr_q[p] + PTR_W'(1) : wr_ptr_q[p];
      rd_ptr_d[p] = pop[p]  ? rd_ptr_q[p] + PTR_W'(1) : rd_ptr_q[p];
      cnt_d[p]    = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      if (push[p]) mem_d[p][wr_ptr_q[p]] = flit_in[p];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int o = 0; o < 5; o++) begin
      flit_d[o]   = flit_q[o];
      rr_ptr_d[o] = rr_ptr_q[o];
      if (gnt_any[o]) begin
        valid_d[o]  = 1'b1;
        flit_d[o]   = head[gnt_idx[o]];
        rr_ptr_d[o] = (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
      end else if (ready_in[o]) begin
        valid_d[o] = 1'b0;
      end
    end
  end

  always_comb begin
    valid_out = valid_q;
    for (int o = 0; o < 5; o++) flit_out[o] = flit_q[o];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int p = 0; p < 5; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
        flit_q[p]   <= '0;
        rr_ptr_q[p] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int p = 0; p < 5; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        cnt_q[p]    <= cnt_d[p];
        flit_q[p]   <= flit_d[p];
        rr_ptr_q[p] <= rr_ptr_d[p];
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
